factor_matrix_responder: RTL and testbench

FACTOR_MATRIX_RESPONDER -- requirements
Module: factor_matrix_responder

---
 rtl/factor_matrix_responder.sv | 135 +++++++++++++
 tb/tb_factor_matrix_responder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/factor_matrix_responder.sv
// factor_matrix_responder: one row store per served mode, with a fixed-latency
// read pipeline and a one-cycle completion pulse per request group. Row loads
// go through a single write port; stored rows are kept across reset.
module factor_matrix_responder #(
    parameter int TENSOR_DIMENSIONS      = 3,
    parameter int FACTOR_MATRIX_WIDTH    = 32,
    parameter int RANK_FACTOR_MATRIX     = 16,
    parameter int MODE_TENSOR_ADDR_WIDTH = 16,
    parameter int FACTOR_MEM_DEPTH       = 1024,
    parameter int READ_LATENCY           = 2,
    localparam int M  = TENSOR_DIMENSIONS - 1,
    localparam int AW = MODE_TENSOR_ADDR_WIDTH,
    localparam int RW = RANK_FACTOR_MATRIX * FACTOR_MATRIX_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [M-1:0]          output_factor_matrices_addr_en,
    input  logic [M*AW-1:0]       output_factor_matrices_addr,
    output logic [M-1:0]          input_factor_matrices_en,
    output logic [M*RW-1:0]       input_factor_matrices,
    output logic                  factor_data_ack,
    input  logic                  fm_wr_en,
    input  logic [$clog2(M):0]    fm_wr_mode,
    input  logic [AW-1:0]         fm_wr_addr,
    input  logic [RW-1:0]         fm_wr_data,
    output logic                  busy,
    output logic                  addr_err
);

    localparam int          IW      = (FACTOR_MEM_DEPTH > 1) ? $clog2(FACTOR_MEM_DEPTH) : 1;
    localparam int          CW      = $clog2(READ_LATENCY) + 1;
    localparam logic [31:0] DEPTH_U = 32'(FACTOR_MEM_DEPTH);

    logic [M*RW-1:0] w_rd_data;
    logic [M-1:0]    w_oor;
    logic            w_req;
    logic            w_ret;
    logic            w_load_ok;
    logic [CW-1:0]   w_cnt_next;

    logic [M-1:0]    r_vld  [READ_LATENCY];
    logic [M*RW-1:0] r_data [READ_LATENCY];
    logic            r_grp  [READ_LATENCY];
    logic [M-1:0]    r_oor;
    logic            r_err;
    logic [CW-1:0]   r_cnt;

    // Loads are only honoured once reset has been released.
    assign w_load_ok = fm_wr_en & ~rst;
    assign w_req     = |output_factor_matrices_addr_en;
    // A group retires on the edge that ends its ack cycle.
    assign w_ret     = r_grp[READ_LATENCY-1];

    for (genvar g = 0; g < M; g++) begin : g_mode
        logic [RW-1:0] r_mem [FACTOR_MEM_DEPTH];
        logic [AW-1:0] w_rd_addr;
        logic          w_rd_inr;
        logic          w_wr_hit;

        assign w_rd_addr = output_factor_matrices_addr[g*AW +: AW];
        assign w_rd_inr  = (32'(w_rd_addr) < DEPTH_U);
        assign w_wr_hit  = w_load_ok && (32'(fm_wr_mode) == 32'(g)) && (32'(fm_wr_addr) < DEPTH_U);

        // Row store write port; no reset so contents survive a reset pulse.
        always_ff @(posedge clk) begin
            if (w_wr_hit) begin
                r_mem[fm_wr_addr[IW-1:0]] <= fm_wr_data;
            end
        end

        // The read is captured on the same edge as any load, so it sees the old row.
        assign w_rd_data[g*RW +: RW] = (output_factor_matrices_addr_en[g] && w_rd_inr)
                                       ? r_mem[w_rd_addr[IW-1:0]] : '0;
        assign w_oor[g]              = output_factor_matrices_addr_en[g] && !w_rd_inr;
    end

    // Read pipeline: stage 0 captures the row, last stage drives the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_vld[i]  <= '0;
                r_data[i] <= '0;
                r_grp[i]  <= 1'b0;
            end
        end else begin
            r_vld[0]  <= output_factor_matrices_addr_en;
            r_data[0] <= w_rd_data;
            r_grp[0]  <= w_req;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_data[i] <= r_data[i-1];
                r_grp[i]  <= r_grp[i-1];
            end
        end
    end

    // Sticky out-of-range flag, raised the edge after the bad request is sampled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_oor <= '0;
            r_err <= 1'b0;
        end else begin
            r_oor <= w_oor;
            if (|r_oor) begin
                r_err <= 1'b1;
            end
        end
    end

    // Next in-flight group count: up on request, down on ack, hold when both.
    always_comb begin
        w_cnt_next = r_cnt;
        case ({w_req, w_ret})
            2'b10:   w_cnt_next = r_cnt + CW'(1);
            2'b01:   w_cnt_next = r_cnt - CW'(1);
            default: w_cnt_next = r_cnt;
        endcase
    end

    // In-flight group counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    assign input_factor_matrices_en = r_vld[READ_LATENCY-1];
    assign input_factor_matrices    = r_data[READ_LATENCY-1];
    assign factor_data_ack          = r_grp[READ_LATENCY-1];
    assign busy                     = (r_cnt != '0);
    assign addr_err                 = r_err;

endmodule

// File: tb/tb_factor_matrix_responder.sv
// Scoreboard bench for factor_matrix_responder: a driver issues directed and
// random traffic and pushes expected responses taken from an array model of the
// row stores; an independent monitor pops and compares on every output cycle.
module tb_factor_matrix_responder;

    localparam int M     = 2;
    localparam int W     = 32;
    localparam int R     = 16;
    localparam int AW    = 16;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;
    localparam int RW    = R * W;

    typedef struct {
        int              issue;
        int              due;
        logic [M-1:0]    en;
        logic [M*RW-1:0] data;
    } item_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [M-1:0]    addr_en;
    logic [M*AW-1:0] addr;
    logic [M-1:0]    en_o;
    logic [M*RW-1:0] data_o;
    logic            ack;
    logic            fm_wr_en;
    logic [1:0]      fm_wr_mode;
    logic [AW-1:0]   fm_wr_addr;
    logic [RW-1:0]   fm_wr_data;
    logic            busy;
    logic            addr_err;

    logic [RW-1:0]   mdl [M][DEPTH];
    item_t           sbq [$];
    int              cyc = 0;
    int              err_cyc = 1 << 30;
    int              busy_hi = 0;
    int              compared = 0;
    int              mismatched = 0;

    factor_matrix_responder #(
        .TENSOR_DIMENSIONS(3), .FACTOR_MATRIX_WIDTH(W), .RANK_FACTOR_MATRIX(R),
        .MODE_TENSOR_ADDR_WIDTH(AW), .FACTOR_MEM_DEPTH(DEPTH), .READ_LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .output_factor_matrices_addr_en(addr_en),
        .output_factor_matrices_addr(addr),
        .input_factor_matrices_en(en_o),
        .input_factor_matrices(data_o),
        .factor_data_ack(ack),
        .fm_wr_en(fm_wr_en), .fm_wr_mode(fm_wr_mode),
        .fm_wr_addr(fm_wr_addr), .fm_wr_data(fm_wr_data),
        .busy(busy), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] rand_row();
        logic [RW-1:0] r;
        for (int i = 0; i < R; i++) r[i*W +: W] = $urandom();
        return r;
    endfunction

    // One clock of stimulus; expected reads use the model before this cycle's load.
    task automatic step(input logic we, input logic [1:0] wm, input logic [AW-1:0] wa,
                        input logic [RW-1:0] wd, input logic [M-1:0] ren,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        item_t it;
        logic [AW-1:0] a;
        @(posedge clk);
        #1;
        fm_wr_en   = we;
        fm_wr_mode = wm;
        fm_wr_addr = wa;
        fm_wr_data = wd;
        addr_en    = ren;
        addr       = {a1, a0};
        if (ren != '0) begin
            it.issue = cyc;
            it.due   = cyc + LAT;
            it.en    = ren;
            it.data  = '0;
            for (int m = 0; m < M; m++) begin
                a = (m == 0) ? a0 : a1;
                if (ren[m]) begin
                    if (int'(a) < DEPTH) it.data[m*RW +: RW] = mdl[m][a];
                    else if (err_cyc > cyc + 2) err_cyc = cyc + 2;
                end
            end
            sbq.push_back(it);
        end
        if (we && int'(wm) < M && int'(wa) < DEPTH) mdl[wm][wa] = wd;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, '0, '0, 2'b00, '0, '0);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst = 1'b1;
        fm_wr_en = 1'b0;
        addr_en = '0;
        sbq.delete();
        err_cyc = 1 << 30;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic random_traffic(input int n, input bit allow_oor);
        logic [AW-1:0] a0, a1, wa;
        for (int i = 0; i < n; i++) begin
            a0 = AW'($urandom_range(0, 15));
            a1 = AW'($urandom_range(0, 15));
            wa = AW'($urandom_range(0, 15));
            if (allow_oor && $urandom_range(0, 9) == 0) a1 = AW'($urandom_range(DEPTH, 2000));
            if ($urandom_range(0, 9) == 0) wa = AW'($urandom_range(DEPTH, 2000));
            step($urandom_range(0, 2) == 0, 2'($urandom_range(0, 2)), wa, rand_row(),
                 2'($urandom_range(0, 3)), a0, a1);
        end
    endtask

    // Monitor: reset state, busy/addr_err from the scoreboard, and response matching.
    initial begin
        item_t it;
        int    nb;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_ctrl", RW'({en_o, ack, busy, addr_err}), '0);
                chk("rst_lane0", data_o[0 +: RW], '0);
                chk("rst_lane1", data_o[RW +: RW], '0);
            end else begin
                nb = 0;
                foreach (sbq[i]) if (sbq[i].issue + 1 <= cyc) nb++;
                if (busy) busy_hi++;
                chk("busy", RW'(busy), RW'(nb != 0));
                chk("addr_err", RW'(addr_err), RW'(cyc >= err_cyc));
                if (ack || en_o != '0) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_resp", RW'({ack, en_o}), '0);
                    end else begin
                        it = sbq.pop_front();
                        chk("latency", RW'(cyc), RW'(it.due));
                        chk("ack", RW'(ack), RW'(1'b1));
                        chk("en", RW'(en_o), RW'(it.en));
                        chk("lane0", data_o[0 +: RW], it.data[0 +: RW]);
                        chk("lane1", data_o[RW +: RW], it.data[RW +: RW]);
                    end
                end else begin
                    chk("idle_data", RW'(data_o != '0), '0);
                    if (sbq.size() != 0 && sbq[0].due <= cyc) begin
                        it = sbq.pop_front();
                        chk("missing_resp", RW'({ack, en_o}), RW'({1'b1, it.en}));
                    end
                end
            end
        end
    end

    // Driver: directed scenarios then randomized traffic.
    initial begin
        logic [RW-1:0] row;
        int b0;
        rst = 1'b1;
        fm_wr_en = 1'b0; fm_wr_mode = '0; fm_wr_addr = '0; fm_wr_data = '0;
        addr_en = '0; addr = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // preload rows 0..15 of both modes
        for (int m = 0; m < M; m++)
            for (int r = 0; r < 16; r++) step(1'b1, 2'(m), AW'(r), rand_row(), 2'b00, '0, '0);

        // mode0 row5 lane i = i, then single-lane read
        for (int i = 0; i < R; i++) row[i*W +: W] = W'(i);
        step(1'b1, 2'd0, 16'd5, row, 2'b00, '0, '0);
        step(1'b0, 2'd0, '0, '0, 2'b01, 16'd5, '0);
        idle(LAT + 3);

        // four back-to-back groups and busy window length
        b0 = busy_hi;
        for (int i = 0; i < 4; i++) step(1'b0, 2'd0, '0, '0, 2'b11, AW'(i), AW'(i));
        idle(8);
        chk("busy_cycles", RW'(busy_hi - b0), RW'(LAT + 3));

        // read-first on same-cycle load, new data the cycle after
        step(1'b1, 2'd0, 16'd7, {R{32'h0000_0001}}, 2'b00, '0, '0);
        step(1'b1, 2'd0, 16'd7, {R{32'hAAAA_AAAA}}, 2'b01, 16'd7, '0);
        step(1'b0, 2'd0, '0, '0, 2'b01, 16'd7, '0);
        idle(LAT + 2);

        // load to a mode that does not exist leaves stores untouched
        step(1'b1, 2'd2, 16'd3, rand_row(), 2'b00, '0, '0);
        step(1'b0, 2'd0, '0, '0, 2'b11, 16'd3, 16'd3);
        idle(LAT + 2);

        random_traffic(200, 1'b0);
        idle(LAT + 2);

        // reset one cycle after a request: it must never complete
        step(1'b0, 2'd0, '0, '0, 2'b11, 16'd2, 16'd3);
        do_reset(3);
        idle(LAT + 3);
        step(1'b0, 2'd0, '0, '0, 2'b11, 16'd2, 16'd3);
        idle(LAT + 2);

        // out-of-range request on mode 1, then more traffic with sticky flag
        step(1'b0, 2'd0, '0, '0, 2'b10, '0, 16'd1024);
        idle(LAT + 2);
        random_traffic(150, 1'b1);

        idle(LAT + 4);
        chk("drain", RW'(sbq.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
